// File: rtl/gating_pkg.sv
// rtl/gating_pkg.sv - shared encodings for the gating array row drivers
//
// Purpose: instruction encodings seen on a mac_row west port, the feeder FSM
// state type, and a small elaboration-time helper.
package gating_pkg;

  // inst_w encodings: bit0 = load weight, bit1 = execute
  localparam logic [1:0] INST_IDLE = 2'b00;
  localparam logic [1:0] INST_LOAD = 2'b01;
  localparam logic [1:0] INST_EXEC = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    GAP,
    EXEC,
    DRAIN
  } state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/beat_counter.sv
// rtl/beat_counter.sv - generic clearable up-counter for beat/phase counting
//
// Purpose: counts enabled cycles; clear has priority over enable.
// Ports:
//   clk      in   clock, rising edge
//   reset    in   asynchronous active-high reset
//   clr_i    in   synchronous clear to zero
//   en_i     in   increment by one
//   count_o  out  current count
module beat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/mac_row_feeder.sv
// rtl/mac_row_feeder.sv - west-edge weight/activation driver for one mac_tile row
//
// Purpose: runs a pass as LOAD (col weights) -> GAP -> EXEC (num_act
// activations) -> DRAIN (col+1 idle cycles), emitting the in_w/inst_w stream
// a mac_row consumes, one registered beat per accepted upstream handshake.
// Ports:
//   clk, reset         clock (rising edge), asynchronous active-high reset
//   start, num_act     pass request (IDLE only) and activation beat count
//   w_data/w_valid/w_ready   weight stream from upstream buffer
//   a_data/a_valid/a_ready   activation stream from upstream buffer
//   in_w, inst_w       registered west-port data and instruction
//   busy               high whenever the FSM is not IDLE
//   done               one-cycle pulse after the last drain cycle
module mac_row_feeder
  import gating_pkg::*;
#(
  parameter int bw     = 4,
  parameter int col    = 8,
  parameter int cnt_bw = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [cnt_bw-1:0] num_act,
  input  logic [bw-1:0]     w_data,
  input  logic              w_valid,
  output logic              w_ready,
  input  logic [bw-1:0]     a_data,
  input  logic              a_valid,
  output logic              a_ready,
  output logic [bw-1:0]     in_w,
  output logic [1:0]        inst_w,
  output logic              busy,
  output logic              done
);

  // Wide enough for both the drain count (col) and the largest num_act.
  localparam int CW = max_int($clog2(col + 2), cnt_bw);
  localparam logic [CW-1:0] LOAD_LAST  = CW'(col - 1);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(col);

  state_e            state_q;
  logic [cnt_bw-1:0] num_act_q;
  logic [bw-1:0]     in_w_q;
  logic [1:0]        inst_w_q;
  logic              done_q;

  logic          cnt_clr;
  logic          cnt_en;
  logic [CW-1:0] cnt;

  logic w_beat;
  logic a_beat;
  logic load_last;
  logic exec_last;
  logic drain_last;

  // Ready depends on state only, never on same-cycle valid.
  assign w_ready = (state_q == LOAD);
  assign a_ready = (state_q == EXEC);
  assign w_beat  = w_ready && w_valid;
  assign a_beat  = a_ready && a_valid;

  assign load_last  = (cnt == LOAD_LAST);
  // cnt tops out at num_act-1 here, so cnt+1 cannot wrap even for num_act max.
  assign exec_last  = ((cnt + CW'(1)) == CW'(num_act_q));
  assign drain_last = (cnt == DRAIN_LAST);

  // The counter restarts from zero at the entry of every phase.
  always_comb begin
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    case (state_q)
      IDLE:  cnt_clr = 1'b1;
      LOAD: begin
        if (w_beat) begin
          cnt_clr = load_last;
          cnt_en  = !load_last;
        end
      end
      GAP:   cnt_clr = 1'b1;
      EXEC: begin
        if (a_beat) begin
          cnt_clr = exec_last;
          cnt_en  = !exec_last;
        end
      end
      DRAIN: begin
        cnt_clr = drain_last;
        cnt_en  = !drain_last;
      end
      default: cnt_clr = 1'b1;
    endcase
  end

  beat_counter #(
    .W(CW)
  ) u_beat_counter (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (cnt_clr),
    .en_i   (cnt_en),
    .count_o(cnt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      num_act_q <= '0;
      in_w_q    <= '0;
      inst_w_q  <= INST_IDLE;
      done_q    <= 1'b0;
    end else begin
      // Bubble unless a beat is accepted this cycle.
      in_w_q   <= '0;
      inst_w_q <= INST_IDLE;
      done_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            num_act_q <= num_act;
            state_q   <= LOAD;
          end
        end
        LOAD: begin
          if (w_beat) begin
            in_w_q   <= w_data;
            inst_w_q <= INST_LOAD;
            if (load_last) state_q <= GAP;
          end
        end
        GAP: begin
          state_q <= (num_act_q != '0) ? EXEC : DRAIN;
        end
        EXEC: begin
          if (a_beat) begin
            in_w_q   <= a_data;
            inst_w_q <= INST_EXEC;
            if (exec_last) state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (drain_last) begin
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_w   = in_w_q;
  assign inst_w = inst_w_q;
  assign busy   = (state_q != IDLE);
  assign done   = done_q;

endmodule

// File: tb/tb_mac_row_feeder.sv
// tb/tb_mac_row_feeder.sv - self-checking bench for mac_row_feeder
module tb_mac_row_feeder;

  localparam int BW     = 4;
  localparam int COL    = 8;
  localparam int CNT_BW = 8;
  localparam int LIMIT  = 1000;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [CNT_BW-1:0] num_act = '0;
  logic [BW-1:0]     w_data = '0;
  logic              w_valid = 1'b0;
  logic              w_ready;
  logic [BW-1:0]     a_data = '0;
  logic              a_valid = 1'b0;
  logic              a_ready;
  logic [BW-1:0]     in_w;
  logic [1:0]        inst_w;
  logic              busy;
  logic              done;

  mac_row_feeder #(
    .bw    (BW),
    .col   (COL),
    .cnt_bw(CNT_BW)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .num_act(num_act),
    .w_data (w_data),
    .w_valid(w_valid),
    .w_ready(w_ready),
    .a_data (a_data),
    .a_valid(a_valid),
    .a_ready(a_ready),
    .in_w   (in_w),
    .inst_w (inst_w),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [5:0] sb_q[$];

  int p_cycles;
  int p_loads;
  int p_execs;
  int p_aready;
  int p_dones;
  int c_first;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One pass: pulse start, feed both streams, score every non-bubble output
  // beat against the queue, stop at done (or at the abort point / timeout).
  task automatic run_pass(input int n, input bit w_gap, input bit a_gap,
                          input int wb, input int ab, input int abort_at,
                          input int restart_at, input bit tail);
    int         wi;
    int         ai;
    bit         tog;
    bit         fin;
    logic [5:0] e;
    wi = 0; ai = 0; tog = 1'b0; fin = 1'b0;
    p_cycles = 0; p_loads = 0; p_execs = 0; p_aready = 0; p_dones = 0;
    start = 1'b1;
    num_act = CNT_BW'(n);
    @(posedge clk); #1;
    start = 1'b0;
    while (!fin) begin
      if (inst_w == 2'b01) p_loads++;
      if (inst_w == 2'b10) p_execs++;
      if (inst_w != 2'b00) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_beat", 32'({inst_w, in_w}), 32'd0);
        end else begin
          e = sb_q.pop_front();
          chk("beat", 32'({inst_w, in_w}), 32'(e));
        end
      end else begin
        chk("bubble_in_w", 32'(in_w), 32'd0);
      end
      if (a_ready) p_aready++;
      if (done) begin
        p_dones++;
        fin = 1'b1;
      end else if (p_cycles >= LIMIT) begin
        chk("timeout_cycles", p_cycles, 32'd0);
        fin = 1'b1;
      end else if (abort_at >= 0 && a_ready && ai == abort_at) begin
        reset = 1'b1;
        #1;
        chk("abort_inst_w", 32'(inst_w), 32'd0);
        chk("abort_in_w", 32'(in_w), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_a_ready", 32'(a_ready), 32'd0);
        chk("abort_w_ready", 32'(w_ready), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        sb_q.delete();
        #1;
        reset = 1'b0;
        fin = 1'b1;
      end else begin
        w_valid = (wi < COL) && !(w_gap && tog);
        w_data  = BW'(wb + wi);
        a_valid = !(a_gap && tog);
        a_data  = BW'(ab + ai);
        tog     = ~tog;
        start   = (restart_at >= 0) && a_ready && (ai == restart_at);
        num_act = start ? CNT_BW'(7) : CNT_BW'(n);
        if (w_ready && w_valid) begin
          sb_q.push_back({2'b01, w_data});
          wi++;
        end
        if (a_ready && a_valid) begin
          sb_q.push_back({2'b10, a_data});
          ai++;
        end
        @(posedge clk); #1;
        p_cycles++;
      end
    end
    start = 1'b0;
    w_valid = 1'b0;
    a_valid = 1'b0;
    if (tail) begin
      repeat (3) begin
        @(posedge clk); #1;
        if (done) p_dones++;
        chk("tail_busy", 32'(busy), 32'd0);
      end
    end
  endtask

  initial begin
    // Reset state
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_inst_w", 32'(inst_w), 32'd0);
    chk("rst_in_w", 32'(in_w), 32'd0);
    chk("rst_w_ready", 32'(w_ready), 32'd0);
    chk("rst_a_ready", 32'(a_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("idle_busy", 32'(busy), 32'd0);

    // Basic pass: weights 1..8, activations 2..5
    run_pass(4, 1'b0, 1'b0, 1, 2, -1, -1, 1'b1);
    chk("basic_cycles", p_cycles, 32'd22);
    chk("basic_loads", p_loads, 32'd8);
    chk("basic_execs", p_execs, 32'd4);
    chk("basic_dones", p_dones, 32'd1);
    chk("basic_sb_empty", sb_q.size(), 32'd0);

    // Reset during the 3rd EXEC beat, then a clean full pass
    run_pass(4, 1'b0, 1'b0, 3, 9, 2, -1, 1'b0);
    run_pass(4, 1'b0, 1'b0, 1, 2, -1, -1, 1'b1);
    chk("post_abort_cycles", p_cycles, 32'd22);
    chk("post_abort_loads", p_loads, 32'd8);
    chk("post_abort_execs", p_execs, 32'd4);
    chk("post_abort_dones", p_dones, 32'd1);

    // Stalling upstream on every other cycle
    run_pass(3, 1'b1, 1'b1, 5, 11, -1, -1, 1'b1);
    chk("gappy_loads", p_loads, 32'd8);
    chk("gappy_execs", p_execs, 32'd3);
    chk("gappy_dones", p_dones, 32'd1);
    chk("gappy_sb_empty", sb_q.size(), 32'd0);

    // num_act = 0 skips EXEC entirely
    run_pass(0, 1'b0, 1'b0, 7, 1, -1, -1, 1'b1);
    chk("zero_cycles", p_cycles, 32'd18);
    chk("zero_loads", p_loads, 32'd8);
    chk("zero_execs", p_execs, 32'd0);
    chk("zero_a_ready", p_aready, 32'd0);
    chk("zero_dones", p_dones, 32'd1);

    // start re-pulsed during EXEC is ignored
    run_pass(4, 1'b0, 1'b0, 1, 2, -1, 1, 1'b1);
    chk("restart_cycles", p_cycles, 32'd22);
    chk("restart_execs", p_execs, 32'd4);
    chk("restart_dones", p_dones, 32'd1);

    // Back-to-back passes, second start in the done cycle
    run_pass(4, 1'b0, 1'b0, 1, 2, -1, -1, 1'b0);
    c_first = p_cycles;
    run_pass(4, 1'b0, 1'b0, 1, 2, -1, -1, 1'b1);
    chk("b2b_first_cycles", c_first, 32'd22);
    chk("b2b_second_cycles", p_cycles, 32'd22);
    chk("b2b_second_execs", p_execs, 32'd4);
    chk("b2b_second_dones", p_dones, 32'd1);

    // Largest num_act completes without counter wrap
    run_pass(255, 1'b0, 1'b0, 2, 0, -1, -1, 1'b1);
    chk("max_cycles", p_cycles, 32'd273);
    chk("max_execs", p_execs, 32'd255);
    chk("max_dones", p_dones, 32'd1);
    chk("max_sb_empty", sb_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
